// File: rtl/clock_pkg.sv
// clock_pkg: edit-state encoding and field indices shared by the clock/calendar top and display mux
package clock_pkg;
    typedef enum logic {RUN = 1'b0, EDIT = 1'b1} edit_state_t;
    localparam int FIELD_S = 0;
    localparam int FIELD_MI = 1;
    localparam int FIELD_H = 2;
    localparam int FIELD_Y_TU = 3;
    localparam int FIELD_Y_TH = 4;
    localparam int FIELD_MO = 5;
    localparam int FIELD_D = 6;
    localparam int FIELD_COUNT = 7;
endpackage

// File: rtl/clock_edit_ctrl_if.sv
// clock_edit_ctrl_if: raw buttons in, edit/select/strobe/enable signals out
interface clock_edit_ctrl_if import clock_pkg::*; #(
    parameter int NUM_FIELDS = FIELD_COUNT
);
    logic mode_btn;
    logic inc_btn;
    logic dec_btn;
    logic editing;
    logic [NUM_FIELDS-1:0] field_sel;
    logic inc_pulse;
    logic dec_pulse;
    logic tick_en;
    logic [NUM_FIELDS-1:0] display_en;
    modport master (
        output mode_btn, inc_btn, dec_btn,
        input editing, field_sel, inc_pulse, dec_pulse, tick_en, display_en
    );
    modport slave (
        input mode_btn, inc_btn, dec_btn,
        output editing, field_sel, inc_pulse, dec_pulse, tick_en, display_en
    );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: active-low button sync, debounce, press strobe and optional hold-to-repeat
module btn_conditioner #(
    parameter int DEB_CYC = 1_000_000,
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC = 5_000_000,
    parameter bit REPEAT_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    input logic btn,
    input logic hold_clr,
    output logic level,
    output logic press,
    output logic rpt
);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int RMAX = REPEAT_DELAY_CYC > REPEAT_RATE_CYC ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RW = $clog2(RMAX + 1);
    logic s1, s2, rpt_on, deb_done, rpt_hit;
    logic [DW-1:0] deb_cnt;
    logic [RW-1:0] rcnt;
    assign deb_done = deb_cnt == DW'(DEB_CYC - 1);
    assign rpt_hit = rcnt == (rpt_on ? RW'(REPEAT_RATE_CYC - 1) : RW'(REPEAT_DELAY_CYC - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            level <= 1'b1;
            deb_cnt <= '0;
            press <= 1'b0;
            rcnt <= '0;
            rpt_on <= 1'b0;
            rpt <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            deb_cnt <= (s2 == level || deb_done) ? '0 : deb_cnt + 1'b1;
            if (s2 != level && deb_done) level <= s2;
            press <= s2 != level && deb_done && !s2;
            // first strobe after the delay, then one per rate period while held
            if (!REPEAT_EN || hold_clr || level) begin
                rcnt <= '0;
                rpt_on <= 1'b0;
                rpt <= 1'b0;
            end else begin
                rcnt <= rpt_hit ? '0 : rcnt + 1'b1;
                rpt_on <= rpt_on || rpt_hit;
                rpt <= rpt_hit;
            end
        end
    end
endmodule

// File: rtl/clock_edit_ctrl.sv
// clock_edit_ctrl: button conditioning, RUN/EDIT field walk, blink, idle timeout and timebase gating
module clock_edit_ctrl import clock_pkg::*; #(
    parameter int NUM_FIELDS = FIELD_COUNT,
    parameter int DEB_CYC = 1_000_000,
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC = 5_000_000,
    parameter int BLINK_CYC = 12_500_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input logic clk,
    input logic rst,
    clock_edit_ctrl_if.slave bus
);
    localparam int IW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    edit_state_t state, nxt_state;
    logic [IW-1:0] idx, nxt_idx;
    logic [BW-1:0] bcnt, nxt_bcnt;
    logic [TW-1:0] idle_cnt;
    logic [NUM_FIELDS-1:0] sel;
    logic phase, nxt_phase;
    logic mode_press, mode_rpt, mode_lvl, inc_press, inc_rpt, inc_lvl, dec_press, dec_rpt, dec_lvl;
    logic in_edit, both, hold_clr, activity, inc_go, dec_go, last, timeout, refresh, bhit;
    btn_conditioner #(
        .DEB_CYC(DEB_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
        .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b0)
    ) u_mode (
        .clk(clk), .rst(rst), .btn(bus.mode_btn), .hold_clr(1'b1),
        .level(mode_lvl), .press(mode_press), .rpt(mode_rpt)
    );
    btn_conditioner #(
        .DEB_CYC(DEB_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
        .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b1)
    ) u_inc (
        .clk(clk), .rst(rst), .btn(bus.inc_btn), .hold_clr(hold_clr),
        .level(inc_lvl), .press(inc_press), .rpt(inc_rpt)
    );
    btn_conditioner #(
        .DEB_CYC(DEB_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
        .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b1)
    ) u_dec (
        .clk(clk), .rst(rst), .btn(bus.dec_btn), .hold_clr(hold_clr),
        .level(dec_lvl), .press(dec_press), .rpt(dec_rpt)
    );
    // a held mode button also parks auto-repeat so it cannot run on into the next field
    always_comb begin
        in_edit = state == EDIT;
        both = !inc_lvl && !dec_lvl;
        hold_clr = !in_edit || both || !mode_lvl;
        activity = mode_press || mode_rpt || inc_press || inc_rpt || dec_press || dec_rpt;
        inc_go = in_edit && (inc_press || inc_rpt) && !both && !mode_press;
        dec_go = in_edit && (dec_press || dec_rpt) && !both && !mode_press;
        last = idx == IW'(NUM_FIELDS - 1);
        timeout = in_edit && !activity && idle_cnt == TW'(TIMEOUT_CYC - 1);
        nxt_state = (timeout || (mode_press && in_edit && last)) ? RUN : mode_press ? EDIT : state;
        nxt_idx = nxt_state == RUN ? '0 : (mode_press && in_edit) ? idx + 1'b1 : idx;
        refresh = (mode_press && nxt_state == EDIT) || inc_go || dec_go;
        bhit = bcnt == BW'(BLINK_CYC - 1);
        nxt_phase = (nxt_state == RUN || refresh) ? 1'b1 : bhit ? !phase : phase;
        nxt_bcnt = (nxt_state == RUN || refresh || bhit) ? '0 : bcnt + 1'b1;
        sel = NUM_FIELDS'(1) << nxt_idx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            idx <= '0;
            phase <= 1'b1;
            bcnt <= '0;
            idle_cnt <= '0;
            bus.editing <= 1'b0;
            bus.field_sel <= '0;
            bus.inc_pulse <= 1'b0;
            bus.dec_pulse <= 1'b0;
            bus.tick_en <= 1'b1;
            bus.display_en <= '1;
        end else begin
            state <= nxt_state;
            idx <= nxt_idx;
            phase <= nxt_phase;
            bcnt <= nxt_bcnt;
            idle_cnt <= (nxt_state == RUN || activity) ? '0 : idle_cnt + 1'b1;
            bus.editing <= nxt_state == EDIT;
            bus.field_sel <= nxt_state == EDIT ? sel : '0;
            bus.inc_pulse <= inc_go;
            bus.dec_pulse <= dec_go;
            bus.tick_en <= nxt_state == RUN;
            bus.display_en <= ~(sel & {NUM_FIELDS{!nxt_phase}});
        end
    end
endmodule

// File: tb/tb_clock_edit_ctrl.sv
// tb_clock_edit_ctrl: directed scenarios with hand-computed expectations for clock_edit_ctrl
module tb_clock_edit_ctrl;
    localparam int NF = 7;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    clock_edit_ctrl_if #(.NUM_FIELDS(NF)) bus ();
    clock_edit_ctrl #(
        .NUM_FIELDS(NF), .DEB_CYC(4), .REPEAT_DELAY_CYC(20),
        .REPEAT_RATE_CYC(5), .BLINK_CYC(8), .TIMEOUT_CYC(100)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic click();
        bus.mode_btn = 1'b0;
        cyc(7);
        bus.mode_btn = 1'b1;
        cyc(8);
    endtask
    task automatic test_reset();
        bus.mode_btn = 1'b1;
        bus.inc_btn = 1'b1;
        bus.dec_btn = 1'b1;
        rst = 1'b0;
        cyc(2);
        vectors++;
        if ({bus.editing, bus.field_sel, bus.inc_pulse, bus.dec_pulse, bus.tick_en, bus.display_en} !== {1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h7f}) begin
            miscompares++;
            $display("FAIL reset_outputs: got ed=%b sel=%b inc=%b dec=%b tick=%b disp=%b want 0 0000000 0 0 1 1111111",
                     bus.editing, bus.field_sel, bus.inc_pulse, bus.dec_pulse, bus.tick_en, bus.display_en);
        end
        rst = 1'b1;
        cyc(2);
    endtask
    task automatic test_glitch();
        bus.mode_btn = 1'b0;
        cyc(3);
        bus.mode_btn = 1'b1;
        cyc(20);
        vectors++;
        if (bus.editing !== 1'b0 || bus.field_sel !== 7'h00) begin
            miscompares++;
            $display("FAIL glitch_ignored: got editing=%b sel=%b want 0 0000000", bus.editing, bus.field_sel);
        end
    endtask
    task automatic test_mode_walk();
        logic [NF-1:0] exp;
        bus.mode_btn = 1'b0;
        cyc(6);
        vectors++;
        if (bus.editing !== 1'b0) begin
            miscompares++;
            $display("FAIL press_latency_early: got editing=%b want 0", bus.editing);
        end
        cyc(1);
        vectors++;
        if (bus.editing !== 1'b1 || bus.tick_en !== 1'b0) begin
            miscompares++;
            $display("FAIL enter_edit: got editing=%b tick_en=%b want 1 0", bus.editing, bus.tick_en);
        end
        bus.mode_btn = 1'b1;
        cyc(8);
        vectors++;
        if (bus.field_sel !== 7'b0000001) begin
            miscompares++;
            $display("FAIL walk_sel0: got %b want 0000001", bus.field_sel);
        end
        for (int i = 1; i < NF; i++) begin
            click();
            exp = NF'(1) << i;
            vectors++;
            if (bus.field_sel !== exp || bus.editing !== 1'b1) begin
                miscompares++;
                $display("FAIL walk_sel%0d: got sel=%b editing=%b want %b 1", i, bus.field_sel, bus.editing, exp);
            end
        end
        click();
        vectors++;
        if (bus.editing !== 1'b0 || bus.tick_en !== 1'b1 || bus.field_sel !== 7'h00) begin
            miscompares++;
            $display("FAIL walk_exit: got editing=%b tick_en=%b sel=%b want 0 1 0000000", bus.editing, bus.tick_en, bus.field_sel);
        end
    endtask
    task automatic test_inc_repeat();
        int n_inc = 0;
        int n_dec = 0;
        int first = 0;
        int second = 0;
        repeat (3) click();
        vectors++;
        if (bus.field_sel !== 7'b0000100) begin
            miscompares++;
            $display("FAIL inc_field_setup: got %b want 0000100", bus.field_sel);
        end
        bus.inc_btn = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            cyc();
            if (bus.inc_pulse === 1'b1) begin
                n_inc++;
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
            if (bus.dec_pulse === 1'b1) n_dec++;
            if (k == 57) bus.inc_btn = 1'b1;
        end
        vectors++;
        if (first != 7 || second != 27) begin
            miscompares++;
            $display("FAIL inc_timing: got first=%0d second=%0d want 7 27", first, second);
        end
        vectors++;
        if (n_inc != 9 || n_dec != 0) begin
            miscompares++;
            $display("FAIL inc_count: got inc=%0d dec=%0d want 9 0", n_inc, n_dec);
        end
        vectors++;
        if (bus.field_sel !== 7'b0000100 || bus.editing !== 1'b1) begin
            miscompares++;
            $display("FAIL inc_field_kept: got sel=%b editing=%b want 0000100 1", bus.field_sel, bus.editing);
        end
    endtask
    task automatic test_both();
        int n = 0;
        int n_inc = 0;
        int n_dec = 0;
        int first = 0;
        bus.inc_btn = 1'b0;
        bus.dec_btn = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (bus.inc_pulse === 1'b1 || bus.dec_pulse === 1'b1) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL both_held: got %0d pulses want 0", n);
        end
        bus.dec_btn = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (bus.inc_pulse === 1'b1) begin
                n_inc++;
                if (first == 0) first = k;
            end
            if (bus.dec_pulse === 1'b1) n_dec++;
        end
        vectors++;
        if (first != 27 || n_inc != 3 || n_dec != 0) begin
            miscompares++;
            $display("FAIL both_release: got first=%0d inc=%0d dec=%0d want 27 3 0", first, n_inc, n_dec);
        end
        bus.inc_btn = 1'b1;
        cyc(10);
    endtask
    task automatic test_timeout_return();
        int w = 0;
        while (bus.editing !== 1'b0 && w < 150) begin
            cyc();
            w++;
        end
        vectors++;
        if (bus.editing !== 1'b0 || bus.field_sel !== 7'h00 || bus.display_en !== 7'h7f) begin
            miscompares++;
            $display("FAIL timeout_return: got editing=%b sel=%b disp=%b after %0d cycles want 0 0000000 1111111",
                     bus.editing, bus.field_sel, bus.display_en, w);
        end
    endtask
    task automatic test_blink_timeout();
        int w = 0;
        logic [NF-1:0] exp;
        bus.mode_btn = 1'b0;
        while (bus.editing !== 1'b1 && w < 20) begin
            cyc();
            w++;
        end
        bus.mode_btn = 1'b1;
        vectors++;
        if (bus.editing !== 1'b1 || w != 7) begin
            miscompares++;
            $display("FAIL blink_enter: got editing=%b after %0d cycles want 1 after 7", bus.editing, w);
        end
        for (int n = 0; n < 100; n++) begin
            exp = ((n / 8) % 2 == 0) ? 7'h7f : 7'h7e;
            vectors++;
            if (bus.display_en !== exp || bus.editing !== 1'b1) begin
                miscompares++;
                $display("FAIL blink_n%0d: got disp=%b editing=%b want %b 1", n, bus.display_en, bus.editing, exp);
            end
            cyc();
        end
        vectors++;
        if (bus.editing !== 1'b0 || bus.tick_en !== 1'b1 || bus.display_en !== 7'h7f) begin
            miscompares++;
            $display("FAIL idle_timeout: got editing=%b tick_en=%b disp=%b want 0 1 1111111", bus.editing, bus.tick_en, bus.display_en);
        end
    endtask
    task automatic test_reset_mid();
        int n = 0;
        int ed = 0;
        click();
        bus.inc_btn = 1'b0;
        cyc(32);
        vectors++;
        if (bus.inc_pulse !== 1'b1 || bus.editing !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_repeat_pulse: got inc=%b editing=%b want 1 1", bus.inc_pulse, bus.editing);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.editing, bus.field_sel, bus.inc_pulse, bus.dec_pulse, bus.tick_en, bus.display_en} !== {1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h7f}) begin
            miscompares++;
            $display("FAIL async_reset: got ed=%b sel=%b inc=%b dec=%b tick=%b disp=%b want 0 0000000 0 0 1 1111111",
                     bus.editing, bus.field_sel, bus.inc_pulse, bus.dec_pulse, bus.tick_en, bus.display_en);
        end
        cyc(2);
        rst = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (bus.inc_pulse === 1'b1 || bus.dec_pulse === 1'b1) n++;
            if (bus.editing !== 1'b0) ed++;
        end
        vectors++;
        if (n != 0 || ed != 0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: got pulses=%0d editing_cycles=%0d want 0 0", n, ed);
        end
        bus.inc_btn = 1'b1;
        cyc(10);
    endtask
    initial begin
        test_reset();
        test_glitch();
        test_mode_walk();
        test_inc_repeat();
        test_both();
        test_timeout_return();
        test_blink_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clock_edit_ctrl.md
# clock_edit_ctrl

Parametrised user-input and edit-mode controller for the digital clock/calendar top. It conditions the mode, increase and decrease push-buttons with synchronisation, debounce, edge detection and hold-to-repeat. It sequences through NUM_FIELDS editable fields and issues one-cycle inc/dec pulses to the field counters. It also gates the 1 s timebase, blinks the field being edited, and returns to normal run after an inactivity timeout.

## Interface
Parameters:
- NUM_FIELDS, 7: number of editable fields (s, mi, h, y_ten_unit, y_thousand_hundred, mo, d order set by the top).
- DEB_CYC, 1_000_000: consecutive stable samples required to accept a button level change.
- REPEAT_DELAY_CYC, 25_000_000: hold time before auto-repeat starts.
- REPEAT_RATE_CYC, 5_000_000: auto-repeat period.
- BLINK_CYC, 12_500_000: half-period of the edit blink.
- TIMEOUT_CYC, 500_000_000: idle cycles in edit before forced return to run.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset. Asynchronous, active-low.
- mode_btn, in, 1: mode button, active-low, asynchronous.
- inc_btn, in, 1: increase button, active-low, asynchronous.
- dec_btn, in, 1: decrease button, active-low, asynchronous.
- editing, out, 1: high when any field is selected.
- field_sel, out, NUM_FIELDS: one-hot selected field; all zero in run.
- inc_pulse, out, 1: one-cycle increment strobe to the selected field.
- dec_pulse, out, 1: one-cycle decrement strobe to the selected field.
- tick_en, out, 1: enables the 1 s pulse generator; low while editing.
- display_en, out, NUM_FIELDS: per-field display enable.

## Operation
- Button path, per button:
  - 2-FF synchroniser.
  - Debounce counter that reloads whenever the sampled level differs from the accepted level; the level is accepted after DEB_CYC equal samples.
  - Press event is the falling edge of the accepted level.
- FSM states are RUN and EDIT, plus index register idx (0..NUM_FIELDS-1).
  - RUN + mode press: go to EDIT, idx=0.
  - EDIT + mode press, idx<NUM_FIELDS-1: idx+1.
  - EDIT + mode press, idx=NUM_FIELDS-1: go to RUN.
  - EDIT + idle counter reaching TIMEOUT_CYC: go to RUN. The idle counter clears on any press event or repeat strobe.
- inc/dec:
  - Active only in EDIT. In RUN, presses are discarded and the repeat timers are held cleared.
  - A press produces one pulse.
  - While the button is held, the first repeat pulse follows REPEAT_DELAY_CYC after the press pulse, then one pulse every REPEAT_RATE_CYC.
  - inc and dec accepted-pressed simultaneously: no pulses, and both repeat timers are held cleared until one is released.
  - A mode press in the same cycle as an inc/dec pulse takes priority; that inc/dec pulse is suppressed.
- Blink:
  - A phase bit toggles every BLINK_CYC in EDIT.
  - display_en[idx] = phase; all other bits are 1.
  - Phase is forced visible (1) and the blink counter cleared on entering a field and on every inc/dec pulse.
  - In RUN, display_en is all ones.
- tick_en = ~editing.
- The timebase is paused, not reset, across edit.

## Timing
- Reset values:
  - State RUN, idx=0, editing=0, field_sel=0, inc_pulse=0, dec_pulse=0.
  - tick_en=1, display_en all ones, phase=1.
  - All accepted button levels = 1 (released); all counters 0.
- Press latency: 2 synchroniser cycles plus DEB_CYC stable cycles. The pulse or state change is registered on the following edge.
- Glitches shorter than DEB_CYC cycles produce no event.
- All outputs are registered. field_sel and editing change on the same edge as the state.
- tick_en drops on the edge that enters EDIT.
- Reset asserted mid-edit returns every output to its reset value asynchronously.

## Structure
- Package clock_pkg holds:
  - The state encoding for RUN and EDIT.
  - Field index constants (FIELD_S=0 .. FIELD_D=6), shared with the top and the display mux.
- Sub-module btn_conditioner: synchroniser, debounce, press edge and hold-repeat.
  - Parameter REPEAT_EN.
  - Instantiated three times; the mode instance has REPEAT_EN=0.
- The FSM, idle timer and blink generator live in clock_edit_ctrl.

## Test plan
All scenarios use DEB_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, BLINK_CYC=8, TIMEOUT_CYC=100, NUM_FIELDS=7.

- mode held low 3 cycles, then released -> no state change; editing stays 0.
- mode pressed 8 times with clean presses -> field_sel walks 0000001 to 1000000, then editing=0, tick_en=1.
- EDIT idx=2 with inc held 60 cycles -> exactly 1+1+7=9 inc_pulse strobes; 0 dec_pulse.
- inc and dec held together in EDIT -> zero pulses. Release dec -> inc repeat restarts from REPEAT_DELAY_CYC.
- EDIT idx=0 with no buttons -> display_en[0] toggles every 8 cycles. At 100 idle cycles: RUN, display_en=1111111.
- rst low during inc repeat -> all outputs at reset values within the same cycle, and no pulse after rst is released.
